// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_det_core.sv
// Bit history, fill tracking and length-masked pattern compare; hit_c flags the completing bit.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  output logic               hit_c
);

  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] cand, mask;
  logic               enough;

  // Window = previous bits plus the incoming one; only the low len bits are compared.
  always_comb begin
    hit_c  = 1'b0;
    hist_d = hist_q;
    fill_d = fill_q;
    cand   = {hist_q, bit_i};
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_i));
    end
    enough = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_i);
    hit_c  = shift_i && enough && (((cand ^ pattern_i) & mask) == '0);

    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = cand[MAX_LEN-2:0];
      if (hit_c && !overlap_i) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Session controller around seq_det_core: config latch, IDLE/RUN/DONE sequencing, match counting.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               in,
  input  logic               in_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               match_q, match_d;
  logic               clr_c, shift_c, hit_c;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    if (32'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  seq_det_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_c),
    .shift_i   (shift_c),
    .bit_i     (in),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .overlap_i (overlap_q),
    .hit_c     (hit_c)
  );

  // A stop in RUN discards that cycle's bit so the held count stays exact.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    match_d   = 1'b0;
    clr_c     = 1'b0;
    shift_c   = in_valid && (state_q == ST_RUN) && !stop;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    if (cfg_valid && (state_q == ST_IDLE)) begin
      pattern_d = cfg_pattern;
      len_d     = clamp_len(cfg_len);
      overlap_d = cfg_overlap;
      target_d  = cfg_target;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          clr_c   = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          clr_c   = 1'b1;
        end else if (hit_c) begin
          match_d = 1'b1;
          cnt_d   = cnt_inc;
          if ((target_q != '0) && (cnt_inc == target_q)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          clr_c   = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          clr_c   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= LEN_W'(1);
      overlap_q <= 1'b1;
      target_q  <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
    end
  end

  assign cfg_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign match       = match_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl (MAX_LEN=8, CNT_W=2) with hand-computed expectations.
module tb_seq_detect_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               stop;
  logic               in;
  logic               in_valid;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  int err_cnt = 0;
  int chk_cnt = 0;

  seq_detect_ctrl #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .stop        (stop),
    .in          (in),
    .in_valid    (in_valid),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Config write together with start; both are accepted from IDLE.
  task automatic cfg_start(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                           input logic ov, input logic [CNT_W-1:0] tg);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cfg_target  = tg;
    start       = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  // Bits sent MSB first (bits[n-1] first); exp holds the match expected after each bit.
  task automatic run_stream(input string tag, input int n, input logic [15:0] bits,
                            input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      in       = bits[i];
      in_valid = 1'b1;
      tick();
      check($sformatf("%s_b%0d", tag, n - i), 32'(match), 32'(exp[i]));
    end
    in_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; stop = 1'b0; in = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #11;
    rst = 1'b1;
    tick();

    // Overlapping 1010
    cfg_start(8'b0000_1010, 4'd4, 1'b1, 2'd0);
    check("ov_busy", 32'(busy), 32'd1);
    check("ov_ready", 32'(cfg_ready), 32'd0);
    run_stream("ov", 6, 16'b101010, 16'b000101);
    check("ov_count", 32'(match_count), 32'd2);
    check("ov_busy_end", 32'(busy), 32'd1);
    do_stop();
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_ready", 32'(cfg_ready), 32'd1);
    check("stop_count_held", 32'(match_count), 32'd2);

    // Non-overlapping 1010
    cfg_start(8'b0000_1010, 4'd4, 1'b0, 2'd0);
    check("nov_count0", 32'(match_count), 32'd0);
    run_stream("nov", 6, 16'b101010, 16'b000100);
    check("nov_count", 32'(match_count), 32'd1);
    do_stop();

    // Target 3 with pattern 11
    cfg_start(8'b0000_0011, 4'd2, 1'b1, 2'd3);
    run_stream("tgt", 4, 16'b1111, 16'b0111);
    check("tgt_done", 32'(done), 32'd1);
    check("tgt_busy", 32'(busy), 32'd0);
    check("tgt_ready", 32'(cfg_ready), 32'd0);
    run_stream("tgt_ign", 1, 16'b1, 16'b0);
    check("tgt_count", 32'(match_count), 32'd3);
    check("tgt_done_hold", 32'(done), 32'd1);
    do_stop();
    check("tgt_stop_done", 32'(done), 32'd0);

    // Length 0 clamps to 1; gaps with in_valid low do nothing
    cfg_start(8'b0000_0001, 4'd0, 1'b1, 2'd0);
    run_stream("gap_a", 1, 16'b1, 16'b1);
    in = 1'b1;
    in_valid = 1'b0;
    tick();
    check("gap_1", 32'(match), 32'd0);
    tick();
    check("gap_2", 32'(match), 32'd0);
    run_stream("gap_b", 1, 16'b1, 16'b1);
    check("gap_count", 32'(match_count), 32'd2);

    // Saturation: three more matches make five in total
    run_stream("sat", 3, 16'b111, 16'b111);
    check("sat_count", 32'(match_count), 32'd3);
    check("sat_busy", 32'(busy), 32'd1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_ready", 32'(cfg_ready), 32'd1);
    check("ss_count", 32'(match_count), 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_count", 32'(match_count), 32'd0);
    do_stop();

    // Length above MAX_LEN clamps to MAX_LEN
    cfg_start(8'hFF, 4'd15, 1'b1, 2'd0);
    run_stream("clamp", 9, 16'b1_1111_1111, 16'b0_0000_0011);
    check("clamp_count", 32'(match_count), 32'd2);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    check("arst_count", 32'(match_count), 32'd0);
    check("arst_match", 32'(match), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    #2;
    rst = 1'b1;
    tick();
    // Reset config is pattern 0, len 1, overlap 1, target 0
    start = 1'b1;
    tick();
    start = 1'b0;
    run_stream("post_rst", 3, 16'b010, 16'b101);
    check("post_rst_count", 32'(match_count), 32'd2);
    check("post_rst_busy", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial sequence-detector controller. It holds a run-time pattern of 1 to MAX_LEN bits and an overlap mode, runs a start/stop session over a qualified serial bit stream, flags each match, counts matches and ends the session when a target count is reached. It sits between the configuration/control logic and the serial input path, and replaces fixed-pattern Mealy detectors with one configurable, sequenced block.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- CNT_W, 8, match counter / target width
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override)

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  high only in IDLE; a write takes effect when cfg_valid && cfg_ready
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  pattern length; 0 is stored as 1, >MAX_LEN is stored as MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
- cfg_target  in  CNT_W  matches that end a session; 0 = unlimited
- start  in  1  begin a session (IDLE or DONE)
- stop  in  1  abort the session, return to IDLE
- in  in  1  serial data bit
- in_valid  in  1  qualifies in; bits are consumed only when high
- match  out  1  one-cycle pulse, registered
- match_count  out  CNT_W  matches in the current session, saturates at all-ones
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cfg_ready=1. A config write latches pattern, clamped len, overlap and target. start -> RUN: clears match_count, the history shift register and the fill counter.
- RUN: on each in_valid cycle, hist <= {hist[MAX_LEN-2:0], in}; fill <= min(fill+1, MAX_LEN). A bit completes a match when fill >= len-1 and {hist[len-2:0], in} == pattern[len-1:0]. For len=1, the check is in == pattern[0].
- On a match: match pulses, match_count increments with saturation. If overlap=0, fill is reset to 0, so the completing bit is not reused.
- If target != 0 and the incremented count equals target, go to DONE in the same edge.
- DONE: the input is ignored and match_count is held. start -> RUN with a cleared session. Config writes are not accepted in DONE.
- stop in RUN or DONE -> IDLE. match_count is held; history and fill are cleared.
- If start and stop arrive in the same cycle, stop wins. In IDLE, a config write and start in the same cycle are both accepted, and the new config is used from the first RUN cycle.
- Reset values: state=IDLE, cfg_ready=1, match=0, match_count=0, busy=0, done=0, pattern=0, len=1, overlap=1, target=0. Reset asserted mid-session aborts immediately, with no completion.

## Timing
- match rises on the clock edge after the completing bit is sampled (1-cycle latency) and lasts 1 cycle.
- match_count updates on the same edge as the match pulse.
- busy drops and done rises on the same edge as the target-reaching match pulse.
- Bits with in_valid=0 do not shift, fill, or time out; gaps of any length are allowed.
- start or stop take effect on the next edge. in_valid bits in the cycle start is sampled are ignored.

## Structure
- A shared package, seq_det_pkg, holds the state enum (IDLE/RUN/DONE) and the MAX_LEN/CNT_W defaults.
- One sub-module, seq_det_core: history shift register, fill counter, masked compare and overlap clear. It outputs a combinational hit.
- The top level holds the FSM, config registers, counter and output registers.

## Test plan
- Overlap: pattern=4'b1010, len=4, overlap=1, target=0; stream 1,0,1,0,1,0 -> match pulses after bits 4 and 6; match_count=2; busy stays 1.
- Non-overlap: same stream with overlap=0 -> single match after bit 4; match_count=1.
- Target: pattern=2'b11, len=2, overlap=1, target=3; stream 1,1,1,1,1 -> matches after bits 2, 3 and 4; done=1 and busy=0 on the third-match edge; bit 5 ignored; count=3.
- Gaps and length clamp: cfg_len=0, pattern bit0=1; stream 1,gap,gap,1 with in_valid low during gaps -> exactly 2 matches.
- Saturation and restart: CNT_W=2, target=0, 5 matches -> count stays 3. Then stop+start in the same cycle -> IDLE with count 3. Then start -> count 0.
- Reset mid-RUN: drive rst low asynchronously between edges -> all outputs return to reset values immediately; cfg_ready=1; len=1.
